uart_rx: RTL

UART receive path, the line-side counterpart to the TX stage: deserialises the asynchronous serial input into bytes and buffers them in an internal FIFO for the register interface.
- Frame format is run-time configurable with the same encoding as the TX stage (5–8 data bits, optional parity, 1/2 stop bits).
- Bit timing is 16x oversampled, driven by an external strobe generator that this block enables and disables.
- Reports sticky parity, framing and overflow errors, plus a FIFO fill-level threshold flag.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 47 ++++
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, oversampling constants and the
// fill-level threshold decode used by both the RX and TX FIFOs.
// No logic of its own; imported by uart_rx and uart_rx_sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Strobe ticks at which the line is sampled; the last one is the decision tick.
  localparam logic [2:0][3:0] SAMPLE_TICKS = {4'd9, 4'd8, 4'd7};

  // Threshold code 0..7 -> 1, 2, 4, 6, 8, 10, 12, 14 entries.
  function automatic logic [6:0] threshold_decode(input logic [2:0] code);
    return (code == 3'd0) ? 7'd1 : {3'b000, code, 1'b0};
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-FF synchroniser, start-edge detect
// and 2-of-3 majority vote over the mid-bit strobes.
// Latency: line visible 2 clk after the pad; bit decision is combinational on
// the decision strobe. No backpressure.
// Ports: clk/rst; rx (async pad); strb + tick from the bit timer;
//        fall (idle->start edge), bit_valid (decision strobe), bit_value (majority).
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       strb,
  input  logic [3:0] tick,
  output logic       fall,
  output logic       bit_valid,
  output logic       bit_value
);

  logic [1:0] sync;
  logic       line;
  logic       line_d;
  logic       samp_a;
  logic       samp_b;

  assign line = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= 2'b11;
      line_d <= 1'b1;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      sync   <= {sync[0], rx};
      line_d <= line;
      if (strb && tick == SAMPLE_TICKS[0]) samp_a <= line;
      if (strb && tick == SAMPLE_TICKS[1]) samp_b <= line;
    end
  end

  assign fall      = line_d & ~line;
  assign bit_valid = strb && (tick == SAMPLE_TICKS[2]);
  // Third sample is the live line on the decision strobe itself.
  assign bit_value = (samp_a & samp_b) | (samp_a & line) | (samp_b & line);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises 5-8 bit frames (optional parity) into an RX FIFO
// with sticky parity/framing/overflow errors and a fill-level threshold flag.
// Latency: byte pushed at the stop-bit decision; read data registered 1 clk
// after i_fifo_rd_en. Backpressure: none on the line -- a push into a full
// FIFO drops the byte and sets o_overflow_error.
// Ports: frame config (i_parity, i_data_bits, i_stop_bits, i_use_parity),
//        FIFO read side (i_fifo_rd_en, o_fifo_rd_data, i_fifo_clear, flags),
//        error flags + i_err_clear, strobe handshake (i_rx_strb, o_rx_strb_en).
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  input  logic       i_parity,
  input  logic [1:0] i_data_bits,
  input  logic       i_stop_bits,
  input  logic       i_use_parity,
  input  logic [2:0] i_threshold_value,
  output logic       o_threshold,
  input  logic       i_fifo_rd_en,
  output logic [7:0] o_fifo_rd_data,
  input  logic       i_fifo_clear,
  output logic       o_fifo_full,
  output logic       o_fifo_empty,
  input  logic       i_err_clear,
  output logic       o_parity_error,
  output logic       o_frame_error,
  output logic       o_overflow_error,
  input  logic       i_rx_strb,
  output logic       o_rx_strb_en
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  rx_state_t  state;
  logic [3:0] tick;
  logic [3:0] bit_cnt;
  logic [3:0] nbits;
  logic       use_par;
  logic       par_odd;
  logic [7:0] shift;

  logic       fall;
  logic       bit_valid;
  logic       bit_value;
  logic       bit_end;

  // The receiver resynchronises on the first stop bit, so the stop-bit count
  // never changes what it does.
  logic       unused_stop_bits;
  assign unused_stop_bits = i_stop_bits;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rx        (i_uart_rx),
    .strb      (i_rx_strb),
    .tick      (tick),
    .fall      (fall),
    .bit_valid (bit_valid),
    .bit_value (bit_value)
  );

  assign bit_end = i_rx_strb && (tick == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RX_IDLE;
      tick         <= '0;
      bit_cnt      <= '0;
      nbits        <= 4'd5;
      use_par      <= 1'b0;
      par_odd      <= 1'b0;
      shift        <= '0;
      o_rx_strb_en <= 1'b0;
    end else begin
      if (state != RX_IDLE && i_rx_strb) tick <= tick + 4'd1;
      case (state)
        RX_IDLE: begin
          o_rx_strb_en <= 1'b0;
          if (fall) begin
            // Frame format is frozen here for the whole frame.
            state        <= RX_START;
            o_rx_strb_en <= 1'b1;
            tick         <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            nbits        <= 4'd5 + {2'b00, i_data_bits};
            use_par      <= i_use_parity;
            par_odd      <= i_parity;
          end
        end
        RX_START: begin
          if (bit_valid && bit_value) begin
            state        <= RX_IDLE;   // glitch, not a start bit
            o_rx_strb_en <= 1'b0;
          end else if (bit_end) begin
            state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (bit_valid) begin
            shift[bit_cnt[2:0]] <= bit_value;
            bit_cnt             <= bit_cnt + 4'd1;
          end
          if (bit_end && bit_cnt == nbits) state <= use_par ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: begin
          if (bit_end) state <= RX_STOP;
        end
        RX_STOP: begin
          if (bit_valid) begin
            state        <= RX_IDLE;
            o_rx_strb_en <= 1'b0;
          end
        end
        default: begin
          state        <= RX_IDLE;
          o_rx_strb_en <= 1'b0;
        end
      endcase
    end
  end

  // Upper shift bits stay zero, so reducing the whole byte covers only data bits.
  logic par_set;
  logic frm_set;
  logic push_req;
  assign par_set  = (state == RX_PARITY) && bit_valid && (bit_value != (par_odd ^ (^shift)));
  assign frm_set  = (state == RX_STOP) && bit_valid && !bit_value;
  assign push_req = (state == RX_STOP) && bit_valid;

  // RX FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;

  assign o_fifo_full  = (count == CW'(FIFO_DEPTH));
  assign o_fifo_empty = (count == '0);
  assign do_push      = push_req && !o_fifo_full;
  assign do_pop       = i_fifo_rd_en && !o_fifo_empty;
  assign ovf_set      = push_req && o_fifo_full;

  always_comb begin
    count_nxt = count;
    if (i_fifo_clear)          count_nxt = '0;
    else if (do_push && !do_pop) count_nxt = count + CW'(1);
    else if (do_pop && !do_push) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      o_fifo_rd_data <= '0;
      o_threshold    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      count       <= count_nxt;
      o_threshold <= 7'(count_nxt) >= threshold_decode(i_threshold_value);
      if (i_fifo_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= shift;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (do_pop) begin
          o_fifo_rd_data <= mem[rd_ptr];
          rd_ptr         <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // Sticky errors: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_parity_error   <= 1'b0;
      o_frame_error    <= 1'b0;
      o_overflow_error <= 1'b0;
    end else begin
      o_parity_error   <= par_set | (o_parity_error   & ~i_err_clear);
      o_frame_error    <= frm_set | (o_frame_error    & ~i_err_clear);
      o_overflow_error <= ovf_set | (o_overflow_error & ~i_err_clear);
    end
  end

endmodule
